// File: rtl/lab5_processor_cpu_ocimem_arbiter_pkg.sv
// Shared definitions for the OCI debug-memory arbiter.
//   - arbiter FSM state encoding
//   - RAM address/data widths
//   - bit positions of the fields carried in the JTAG debug word (jdo)
package lab5_processor_cpu_ocimem_pkg;

    localparam int OCIMEM_AW   = 8;
    localparam int OCIMEM_DW   = 32;
    localparam int OCIMEM_BE_W = OCIMEM_DW / 8;
    localparam int JDO_W       = 38;

    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_DATA_MSB = 34;
    localparam int JDO_ADDR_LSB = 10;
    localparam int JDO_ADDR_MSB = 17;
    localparam int JDO_RD_BIT   = 35;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CPU_WR  = 3'd1,
        ST_CPU_RD  = 3'd2,
        ST_CPU_RDY = 3'd3,
        ST_J_WR    = 3'd4,
        ST_J_RD    = 3'd5,
        ST_J_RDY   = 3'd6
    } ocimem_state_e;

endpackage

// File: rtl/lab5_processor_cpu_ocimem_arbiter_if.sv
// CPU-side debug-memory slave bus.
//   master : CPU (drives address/read/write/writedata/byteenable)
//   slave  : arbiter (drives waitrequest/readdata)
interface lab5_processor_cpu_ocimem_arbiter_if;
    import lab5_processor_cpu_ocimem_pkg::*;

    logic [OCIMEM_AW-1:0]   avl_address;
    logic                   avl_read;
    logic                   avl_write;
    logic [OCIMEM_DW-1:0]   avl_writedata;
    logic [OCIMEM_BE_W-1:0] avl_byteenable;
    logic                   avl_waitrequest;
    logic [OCIMEM_DW-1:0]   avl_readdata;

    modport master (
        output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
        input  avl_waitrequest, avl_readdata
    );

    modport slave (
        input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
        output avl_waitrequest, avl_readdata
    );

endinterface

// File: rtl/lab5_processor_cpu_ocimem_arbiter_ram.sv
// 256x32 single-port RAM, byte-enabled write, registered read data
// (q reflects the addressed word one cycle after the address is presented).
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   be    : byte enables for the write
//   q     : registered read data
module lab5_processor_cpu_ocimem_ram
    import lab5_processor_cpu_ocimem_pkg::*;
(
    input  logic                   clk,
    input  logic                   we,
    input  logic [OCIMEM_AW-1:0]   addr,
    input  logic [OCIMEM_DW-1:0]   wdata,
    input  logic [OCIMEM_BE_W-1:0] be,
    output logic [OCIMEM_DW-1:0]   q
);

    logic [OCIMEM_DW-1:0] mem [2**OCIMEM_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < OCIMEM_BE_W; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/lab5_processor_cpu_ocimem_arbiter.sv
// Arbiter sharing one debug RAM between the CPU slave bus and the JTAG
// debug path (MonAReg/MonDReg).
//   clk, reset_n             : clock, synchronous active-low reset
//   avl (slave modport)      : CPU debug-memory bus
//   jdo                      : JTAG debug word (address, read flag, write data)
//   take_action_ocimem_a     : load MonAReg, optionally queue a read
//   take_no_action_ocimem_a  : queue read at MonAReg, post-increment
//   take_action_ocimem_b     : queue write of jdo data at MonAReg, post-increment
//   MonAReg / MonDReg        : JTAG word address / last JTAG read data
//   jtag_busy / jtag_overrun : JTAG entry pending-or-active / sticky drop flag
// Build option: OCIMEM_ARB_RR_EN selects round-robin on contention;
// otherwise JTAG has fixed priority.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | arbitration point, waitrequest high
// ST_CPU_WR  | CPU write into RAM, waitrequest low (complete)
// ST_CPU_RD  | CPU address presented to RAM
// ST_CPU_RDY | RAM q on avl_readdata, waitrequest low (complete)
// ST_J_WR    | JTAG write into RAM at MonAReg
// ST_J_RD    | JTAG address presented to RAM
// ST_J_RDY   | RAM q captured into MonDReg
module lab5_processor_cpu_ocimem_arbiter
    import lab5_processor_cpu_ocimem_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    lab5_processor_cpu_ocimem_arbiter_if.slave avl,
    input  logic [JDO_W-1:0]     jdo,
    input  logic                 take_action_ocimem_a,
    input  logic                 take_no_action_ocimem_a,
    input  logic                 take_action_ocimem_b,
    output logic [OCIMEM_AW-1:0] MonAReg,
    output logic [OCIMEM_DW-1:0] MonDReg,
    output logic                 jtag_busy,
    output logic                 jtag_overrun
);

    ocimem_state_e          state;
    logic                   waitreq_q;
    logic [OCIMEM_DW-1:0]   rd_hold;
    logic [OCIMEM_AW-1:0]   cpu_addr;
    logic [OCIMEM_DW-1:0]   cpu_wdata;
    logic [OCIMEM_BE_W-1:0] cpu_be;
    logic                   jq_valid, jq_write, jq_inc;
    logic [OCIMEM_DW-1:0]   jq_data;

    logic                   ram_we;
    logic [OCIMEM_AW-1:0]   ram_addr;
    logic [OCIMEM_DW-1:0]   ram_wdata;
    logic [OCIMEM_BE_W-1:0] ram_be;
    logic [OCIMEM_DW-1:0]   ram_q;

    logic cpu_req, pulse_any, accept_a, in_valid, in_write, in_inc;
    logic jtag_pend, pend_write, grant_jtag, grant_cpu;

    wire unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0]};

    assign cpu_req   = avl.avl_read | avl.avl_write;
    assign pulse_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign accept_a  = take_action_ocimem_a & ~jtag_busy;

    // A new pulse competes in the same IDLE cycle it arrives, so it is
    // treated as pending alongside an already-queued entry. When several
    // pulses coincide, action_a wins, then no_action_a, then action_b.
    assign in_valid  = ~jtag_busy & ((take_action_ocimem_a & jdo[JDO_RD_BIT])
                                     | take_no_action_ocimem_a | take_action_ocimem_b);
    assign in_write  = ~take_action_ocimem_a & ~take_no_action_ocimem_a & take_action_ocimem_b;
    assign in_inc    = ~take_action_ocimem_a;

    assign jtag_pend  = jq_valid | in_valid;
    assign pend_write = jq_valid ? jq_write : in_write;

`ifdef OCIMEM_ARB_RR_EN
    logic last_grant_cpu;
    assign grant_jtag = jtag_pend & (~cpu_req | last_grant_cpu);
`else
    assign grant_jtag = jtag_pend;
`endif
    assign grant_cpu  = cpu_req & ~grant_jtag;

    // RAM writes are gated by reset_n so a reset edge never commits a write.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_be    = cpu_be;
        case (state)
            ST_CPU_WR: ram_we = reset_n;
            ST_J_WR: begin
                ram_we    = reset_n;
                ram_addr  = MonAReg;
                ram_wdata = jq_data;
                ram_be    = '1;
            end
            ST_J_RD:   ram_addr = MonAReg;
            default:   ;
        endcase
    end

    lab5_processor_cpu_ocimem_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .be    (ram_be),
        .q     (ram_q)
    );

    // RAM q only lands during CPU_RDY, so readdata bypasses q there and
    // holds the captured word everywhere else.
    assign avl.avl_readdata    = (state == ST_CPU_RDY) ? ram_q : rd_hold;
    assign avl.avl_waitrequest = waitreq_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            waitreq_q    <= 1'b1;
            rd_hold      <= '0;
            MonAReg      <= '0;
            MonDReg      <= '0;
            jtag_busy    <= 1'b0;
            jtag_overrun <= 1'b0;
            jq_valid     <= 1'b0;
            jq_write     <= 1'b0;
            jq_inc       <= 1'b0;
            jq_data      <= '0;
            cpu_addr     <= '0;
            cpu_wdata    <= '0;
            cpu_be       <= '0;
`ifdef OCIMEM_ARB_RR_EN
            last_grant_cpu <= 1'b1;
`endif
        end else begin
            waitreq_q <= 1'b1;
            if (pulse_any && jtag_busy) jtag_overrun <= 1'b1;
            if (accept_a) MonAReg <= jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
            if (in_valid) begin
                jq_valid  <= 1'b1;
                jq_write  <= in_write;
                jq_inc    <= in_inc;
                jq_data   <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                jtag_busy <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (grant_jtag) begin
                        jq_valid <= 1'b0;
                        state    <= pend_write ? ST_J_WR : ST_J_RD;
`ifdef OCIMEM_ARB_RR_EN
                        if (cpu_req) last_grant_cpu <= 1'b0;
`endif
                    end else if (grant_cpu) begin
                        cpu_addr  <= avl.avl_address;
                        cpu_wdata <= avl.avl_writedata;
                        cpu_be    <= avl.avl_byteenable;
                        if (avl.avl_write) begin
                            state     <= ST_CPU_WR;
                            waitreq_q <= 1'b0;
                        end else begin
                            state <= ST_CPU_RD;
                        end
`ifdef OCIMEM_ARB_RR_EN
                        if (jtag_pend) last_grant_cpu <= 1'b1;
`endif
                    end
                end
                ST_CPU_WR: state <= ST_IDLE;
                ST_CPU_RD: begin
                    state     <= ST_CPU_RDY;
                    waitreq_q <= 1'b0;
                end
                ST_CPU_RDY: begin
                    rd_hold <= ram_q;
                    state   <= ST_IDLE;
                end
                ST_J_WR: begin
                    if (jq_inc) MonAReg <= MonAReg + 8'd1;
                    jtag_busy <= 1'b0;
                    state     <= ST_IDLE;
                end
                ST_J_RD: state <= ST_J_RDY;
                ST_J_RDY: begin
                    MonDReg <= ram_q;
                    if (jq_inc) MonAReg <= MonAReg + 8'd1;
                    jtag_busy <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab5_processor_cpu_ocimem_arbiter.sv
// Directed bench for the OCI debug-memory arbiter. CPU transfers push the
// expected completion into a scoreboard queue; a negedge monitor pops and
// compares whenever the DUT drops waitrequest.
module tb_lab5_processor_cpu_ocimem_arbiter;
    import lab5_processor_cpu_ocimem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta_a, tna_a, ta_b;
    logic [7:0]  mon_a;
    logic [31:0] mon_d;
    logic        busy, ovr;

    lab5_processor_cpu_ocimem_arbiter_if avl_if ();

    lab5_processor_cpu_ocimem_arbiter dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .avl                     (avl_if),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_no_action_ocimem_a (tna_a),
        .take_action_ocimem_b    (ta_b),
        .MonAReg                 (mon_a),
        .MonDReg                 (mon_d),
        .jtag_busy               (busy),
        .jtag_overrun            (ovr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (avl_if.avl_waitrequest === 1'b0) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
            end else begin
                e = sb.pop_front();
                if (e.is_rd) check("cpu_readdata", avl_if.avl_readdata, e.data);
                else         check("cpu_write_ack", 32'(avl_if.avl_write), 32'd1);
            end
        end
    end

    function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] a);
        jdo_a = {2'b00, rd, 17'd0, a, 10'd0};
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        jdo_b = {3'b000, d, 3'b000};
    endfunction

    task automatic cpu_xfer(input logic wr, input logic rd, input logic [7:0] a,
                            input logic [31:0] d, input logic [3:0] be,
                            input logic [31:0] exp_rd, input int exp_cyc, input string nm);
        int   cyc;
        bit   done;
        exp_t e;
        cyc = 0;
        done = 0;
        e.is_rd = ~wr;
        e.data  = exp_rd;
        sb.push_back(e);
        @(posedge clk); #1;
        avl_if.avl_address    = a;
        avl_if.avl_read       = rd;
        avl_if.avl_write      = wr;
        avl_if.avl_writedata  = d;
        avl_if.avl_byteenable = be;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (avl_if.avl_waitrequest === 1'b0) done = 1;
        end
        @(posedge clk); #1;
        avl_if.avl_read  = 1'b0;
        avl_if.avl_write = 1'b0;
        check({nm, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        @(negedge clk);
        check({nm, "_wait_high"}, 32'(avl_if.avl_waitrequest), 32'd1);
    endtask

    task automatic jpulse(input int kind, input logic [37:0] j);
        @(posedge clk); #1;
        jdo = j;
        case (kind)
            0:       ta_a  = 1'b1;
            1:       tna_a = 1'b1;
            default: ta_b  = 1'b1;
        endcase
        @(posedge clk); #1;
        ta_a  = 1'b0;
        tna_a = 1'b0;
        ta_b  = 1'b0;
    endtask

    task automatic wait_jtag_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_jtag_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp2;
        int          cyc2;
        exp_t        e;

        reset_n = 1'b0;
        jdo = '0; ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
        avl_if.avl_address = '0; avl_if.avl_read = 1'b0; avl_if.avl_write = 1'b0;
        avl_if.avl_writedata = '0; avl_if.avl_byteenable = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_waitrequest", 32'(avl_if.avl_waitrequest), 32'd1);
        check("rst_readdata", avl_if.avl_readdata, 32'd0);
        check("rst_monareg", 32'(mon_a), 32'd0);
        check("rst_mondreg", mon_d, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(ovr), 32'd0);

        // basic CPU write then read
        cpu_xfer(1, 0, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2, "cpu_wr10");
        cpu_xfer(0, 1, 8'h10, 32'h0, 4'hF, 32'hDEADBEEF, 3, "cpu_rd10");

        // JTAG load address with read
        jpulse(0, jdo_a(1'b1, 8'h10));
        wait_jtag_idle("jrd10");
        check("jrd10_monareg", 32'(mon_a), 32'h10);
        check("jrd10_mondreg", mon_d, 32'hDEADBEEF);

        // JTAG write at 0xFF wraps address
        jpulse(0, jdo_a(1'b0, 8'hFF));
        @(negedge clk);
        check("load_ff_monareg", 32'(mon_a), 32'hFF);
        check("load_ff_busy", 32'(busy), 32'd0);
        jpulse(2, jdo_b(32'h12345678));
        wait_jtag_idle("jwr_ff");
        check("jwr_ff_wrap", 32'(mon_a), 32'h00);
        cpu_xfer(0, 1, 8'hFF, 32'h0, 4'hF, 32'h12345678, 3, "cpu_rd_ff");

        // byte enables
        cpu_xfer(1, 0, 8'h40, 32'hAABBCCDD, 4'hF, 32'h0, 2, "cpu_wr40");
        cpu_xfer(1, 0, 8'h40, 32'h11223344, 4'b0101, 32'h0, 2, "cpu_wr40_be");
        cpu_xfer(0, 1, 8'h40, 32'h0, 4'hF, 32'hAA22CC44, 3, "cpu_rd40");

        // read and write together is a write
        cpu_xfer(1, 1, 8'h50, 32'h5555AAAA, 4'hF, 32'h0, 2, "cpu_rdwr50");
        cpu_xfer(0, 1, 8'h50, 32'h0, 4'hF, 32'h5555AAAA, 3, "cpu_rd50");

        // contention: CPU read vs JTAG write to the same word
        cpu_xfer(1, 0, 8'h31, 32'h31313131, 4'hF, 32'h0, 2, "cpu_wr31");
        jpulse(0, jdo_a(1'b0, 8'h30));
        fork
            cpu_xfer(0, 1, 8'h30, 32'h0, 4'hF, 32'hCAFEF00D, 5, "contend1");
            jpulse(2, jdo_b(32'hCAFEF00D));
        join
        wait_jtag_idle("contend1");
        check("contend1_monareg", 32'(mon_a), 32'h31);
`ifdef OCIMEM_ARB_RR_EN
        exp2 = 32'h31313131;
        cyc2 = 3;
`else
        exp2 = 32'h0BADC0DE;
        cyc2 = 5;
`endif
        fork
            cpu_xfer(0, 1, 8'h31, 32'h0, 4'hF, exp2, cyc2, "contend2");
            jpulse(2, jdo_b(32'h0BADC0DE));
        join
        wait_jtag_idle("contend2");
        check("contend2_monareg", 32'(mon_a), 32'h32);

        // overrun: second no_action pulse while busy is dropped
        jpulse(0, jdo_a(1'b0, 8'h10));
        @(negedge clk);
        check("pre_overrun", 32'(ovr), 32'd0);
        @(posedge clk); #1 tna_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 tna_a = 1'b0;
        wait_jtag_idle("overrun");
        check("overrun_set", 32'(ovr), 32'd1);
        check("overrun_monareg", 32'(mon_a), 32'h11);
        check("overrun_mondreg", mon_d, 32'hDEADBEEF);
        repeat (5) @(negedge clk);
        check("overrun_sticky", 32'(ovr), 32'd1);

        // reset during CPU_WR aborts the write
        cpu_xfer(1, 0, 8'h20, 32'h11111111, 4'hF, 32'h0, 2, "cpu_wr20");
        e.is_rd = 1'b0;
        e.data  = 32'h0;
        sb.push_back(e);
        @(posedge clk); #1;
        avl_if.avl_address = 8'h20; avl_if.avl_write = 1'b1;
        avl_if.avl_writedata = 32'h22222222; avl_if.avl_byteenable = 4'hF;
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 avl_if.avl_write = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst2_waitrequest", 32'(avl_if.avl_waitrequest), 32'd1);
        check("rst2_readdata", avl_if.avl_readdata, 32'd0);
        check("rst2_monareg", 32'(mon_a), 32'd0);
        check("rst2_mondreg", mon_d, 32'd0);
        check("rst2_overrun", 32'(ovr), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        cpu_xfer(0, 1, 8'h20, 32'h0, 4'hF, 32'h11111111, 3, "cpu_rd20");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lab5_processor_cpu_ocimem_arbiter.md
LAB5_PROCESSOR_CPU_OCIMEM_ARBITER -- requirements
Module: lab5_processor_cpu_ocimem_arbiter

Interface
REQ-001 SHALL expose: clk  in  1  single system clock; all logic rising-edge.
REQ-002 SHALL expose: reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL expose: jdo  in  38  JTAG debug data word, sysclk domain.
REQ-004 SHALL expose: take_action_ocimem_a  in  1  one-cycle pulse; load MonAReg, optional read.
REQ-005 SHALL expose: take_no_action_ocimem_a  in  1  one-cycle pulse; read at MonAReg, then increment.
REQ-006 SHALL expose: take_action_ocimem_b  in  1  one-cycle pulse; write jdo[34:3] at MonAReg, then increment.
REQ-007 SHALL expose: avl_address  in  8; avl_read  in  1; avl_write  in  1; avl_writedata  in  32; avl_byteenable  in  4.  These are the CPU debug-memory slave inputs.
REQ-008 SHALL expose: avl_waitrequest  out  1; avl_readdata  out  32.
REQ-009 SHALL expose: MonAReg  out  8 (JTAG word address); MonDReg  out  32 (JTAG read data); jtag_busy  out  1; jtag_overrun  out  1 (sticky).

Function
REQ-010 SHALL share one 256x32 single-port RAM (1-cycle read latency) between the CPU requester and the JTAG requester.
REQ-011 SHALL implement FSM states IDLE, CPU_WR, CPU_RD, CPU_RDY, J_WR, J_RD, J_RDY; arbitration SHALL occur only in IDLE.
REQ-012 take_action_ocimem_a SHALL set MonAReg <= jdo[17:10]; if jdo[35]=1, SHALL also queue a JTAG read (no increment).
REQ-013 take_no_action_ocimem_a SHALL queue a JTAG read at MonAReg with post-increment; take_action_ocimem_b SHALL queue a JTAG write of jdo[34:3], byteenable 4'hF, with post-increment.
REQ-014 JTAG queue SHALL be one entry deep; jtag_busy=1 while an entry is pending or in service; a new pulse while jtag_busy=1 SHALL be dropped and set jtag_overrun.
REQ-015 avl_waitrequest SHALL be 1 in every cycle except the completing cycle of a CPU transfer.
REQ-016 CPU write: IDLE (grant) -> CPU_WR, RAM written with byteenable, waitrequest=0 -> IDLE; 2 cycles minimum.
REQ-017 CPU read: IDLE -> CPU_RD (RAM read) -> CPU_RDY (avl_readdata=RAM q, waitrequest=0) -> IDLE; 3 cycles minimum.
REQ-018 JTAG write: IDLE -> J_WR (RAM write, MonAReg increment if flagged) -> IDLE.
REQ-019 JTAG read: IDLE -> J_RD -> J_RDY (MonDReg<=q, increment if flagged) -> IDLE; jtag_busy SHALL clear in the cycle after J_RDY.
REQ-020 MonAReg increment SHALL wrap 8'hFF -> 8'h00.
REQ-021 avl_read and avl_write both high SHALL be treated as write.
REQ-022 Simultaneous JTAG pulse and MonAReg increment SHALL be impossible, because pulses are dropped while busy.
REQ-023 avl_readdata SHALL hold its last value outside CPU_RDY.

Reset
REQ-024 reset_n=0 at a clock edge SHALL force state IDLE, avl_waitrequest=1, avl_readdata=0, MonDReg=0, MonAReg=0, jtag_busy=0, jtag_overrun=0, and clear the JTAG queue.
REQ-025 Reset mid-transfer SHALL abort the transfer, and no RAM write SHALL occur in the reset cycle.

Configuration
REQ-026 With OCIMEM_ARB_RR_EN defined, the arbiter SHALL alternate grants when both requesters are pending in IDLE, using a last-grant flag reset to CPU so that JTAG wins first.
REQ-027 Without OCIMEM_ARB_RR_EN, JTAG SHALL have fixed priority over CPU.

Structure
REQ-028 Package lab5_processor_cpu_ocimem_pkg SHALL hold the FSM state enum, OCIMEM_AW=8, OCIMEM_DW=32, and the jdo field positions.
REQ-029 The RAM SHALL be sub-module lab5_processor_cpu_ocimem_ram (single-port, byte-enabled, registered output).

Verification
REQ-030 Reset, CPU write 0xDEADBEEF to addr 0x10, then CPU read 0x10 -> readdata 0xDEADBEEF with waitrequest low for exactly 1 cycle of each transfer (transfers of 2 and 3 cycles).
REQ-031 take_action_ocimem_a with jdo[17:10]=0x10 and jdo[35]=1 -> MonAReg=0x10 and MonDReg=0xDEADBEEF; MonAReg unchanged.
REQ-032 MonAReg=0xFF, take_action_ocimem_b with data 0x12345678 -> RAM[0xFF]=0x12345678 and MonAReg=0x00.
REQ-033 CPU read and JTAG write pending in the same IDLE cycle -> JTAG served first; with OCIMEM_ARB_RR_EN, a second contention grants CPU first.
REQ-034 Second take_no_action_ocimem_a pulse while jtag_busy=1 -> pulse dropped, jtag_overrun=1 until reset.
REQ-035 reset_n low during CPU_WR -> RAM location unchanged and waitrequest=1 after reset.
